// File: rtl/vram_oam_arbiter_if.sv
// vram_oam_arbiter_if: bus bundle between CPU/PPU/DMA, the VRAM/OAM BRAMs and the arbiter.
interface vram_oam_arbiter_if #(parameter int BLK_CNT_W = 16);
  logic                 lcd_en_in;
  logic [1:0]           ppu_mode_in;
  logic                 cpu_req_in;
  logic [15:0]          cpu_addr_in;
  logic                 cpu_we_in;
  logic [7:0]           cpu_wdata_in;
  logic                 cpu_ack_out;
  logic [7:0]           cpu_rdata_out;
  logic                 ppu_vram_rd_in;
  logic [12:0]          ppu_vram_addr_in;
  logic                 ppu_vram_gnt_out;
  logic                 ppu_vram_vld_out;
  logic                 ppu_oam_rd_in;
  logic [7:0]           ppu_oam_addr_in;
  logic                 ppu_oam_gnt_out;
  logic                 ppu_oam_vld_out;
  logic [7:0]           ppu_rdata_out;
  logic                 dma_active_in;
  logic                 dma_we_in;
  logic [7:0]           dma_addr_in;
  logic [7:0]           dma_wdata_in;
  logic [12:0]          vram_addr_out;
  logic                 vram_we_out;
  logic [7:0]           vram_wdata_out;
  logic [7:0]           vram_rdata_in;
  logic [7:0]           oam_addr_out;
  logic                 oam_we_out;
  logic [7:0]           oam_wdata_out;
  logic [7:0]           oam_rdata_in;
  logic [BLK_CNT_W-1:0] cpu_blk_cnt_out;
  modport slave (
    input  lcd_en_in, ppu_mode_in, cpu_req_in, cpu_addr_in, cpu_we_in, cpu_wdata_in,
           ppu_vram_rd_in, ppu_vram_addr_in, ppu_oam_rd_in, ppu_oam_addr_in,
           dma_active_in, dma_we_in, dma_addr_in, dma_wdata_in, vram_rdata_in, oam_rdata_in,
    output cpu_ack_out, cpu_rdata_out, ppu_vram_gnt_out, ppu_vram_vld_out, ppu_oam_gnt_out,
           ppu_oam_vld_out, ppu_rdata_out, vram_addr_out, vram_we_out, vram_wdata_out,
           oam_addr_out, oam_we_out, oam_wdata_out, cpu_blk_cnt_out
  );
  modport master (
    output lcd_en_in, ppu_mode_in, cpu_req_in, cpu_addr_in, cpu_we_in, cpu_wdata_in,
           ppu_vram_rd_in, ppu_vram_addr_in, ppu_oam_rd_in, ppu_oam_addr_in,
           dma_active_in, dma_we_in, dma_addr_in, dma_wdata_in, vram_rdata_in, oam_rdata_in,
    input  cpu_ack_out, cpu_rdata_out, ppu_vram_gnt_out, ppu_vram_vld_out, ppu_oam_gnt_out,
           ppu_oam_vld_out, ppu_rdata_out, vram_addr_out, vram_we_out, vram_wdata_out,
           oam_addr_out, oam_we_out, oam_wdata_out, cpu_blk_cnt_out
  );
endinterface

// File: rtl/vram_oam_arbiter.sv
// vram_oam_arbiter: shares single-port VRAM/OAM BRAMs between CPU, PPU and OAM DMA by PPU mode.
module vram_oam_arbiter #(
  parameter int BLK_CNT_W = 16
) (
  input logic               clk_in,
  input logic               rst_in,
  vram_oam_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t               state_q, state_d;
  logic [15:0]          addr_q, addr_d;
  logic                 we_q, we_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 pass_q, pass_d;
  logic                 pass_src_q, pass_src_d;
  logic                 ack_q, ack_d;
  logic [BLK_CNT_W-1:0] blk_q, blk_d;
  logic                 vram_vld_q, vram_vld_d;
  logic                 oam_vld_q, oam_vld_d;
  logic                 src_q, src_d;
  logic ppu_vram_own, ppu_oam_own, issue, tgt_vram, oam_hole, cpu_blocked;
  logic cpu_vram_go, cpu_oam_go, ppu_vram_gnt, ppu_oam_gnt;
  logic [7:0] bram_rdata;
  always_comb begin
    ppu_vram_own = bus.lcd_en_in && bus.ppu_mode_in == 2'd3;
    ppu_oam_own  = bus.lcd_en_in && bus.ppu_mode_in[1];
    issue        = state_q == ISSUE;
    tgt_vram     = addr_q[15:13] == 3'b100;
    oam_hole     = addr_q[7:0] >= 8'hA0;
    cpu_blocked  = tgt_vram ? ppu_vram_own : (bus.dma_active_in || ppu_oam_own);
    cpu_vram_go  = issue && tgt_vram && !cpu_blocked;
    cpu_oam_go   = issue && !tgt_vram && !cpu_blocked && !oam_hole;
    ppu_vram_gnt = bus.ppu_vram_rd_in && (ppu_vram_own || !(issue && tgt_vram));
    ppu_oam_gnt  = bus.ppu_oam_rd_in && !bus.dma_active_in && !ppu_vram_gnt &&
                   (ppu_oam_own || !(issue && !tgt_vram));
  end
  assign bus.ppu_vram_gnt_out = ppu_vram_gnt;
  assign bus.ppu_oam_gnt_out  = ppu_oam_gnt;
  assign bus.vram_addr_out    = cpu_vram_go ? addr_q[12:0] : bus.ppu_vram_addr_in;
  assign bus.vram_we_out      = cpu_vram_go && we_q;
  assign bus.vram_wdata_out   = wdata_q;
  // DMA owns the OAM port outright; without a write strobe it simply idles
  assign bus.oam_addr_out  = bus.dma_active_in ? bus.dma_addr_in :
                             cpu_oam_go ? addr_q[7:0] : bus.ppu_oam_addr_in;
  assign bus.oam_we_out    = bus.dma_active_in ? bus.dma_we_in : cpu_oam_go && we_q;
  assign bus.oam_wdata_out = bus.dma_active_in ? bus.dma_wdata_in : wdata_q;
  assign bram_rdata           = pass_src_q ? bus.oam_rdata_in : bus.vram_rdata_in;
  assign bus.cpu_ack_out      = ack_q;
  assign bus.cpu_rdata_out    = pass_q ? bram_rdata : rdata_q;
  assign bus.cpu_blk_cnt_out  = blk_q;
  assign bus.ppu_vram_vld_out = vram_vld_q;
  assign bus.ppu_oam_vld_out  = oam_vld_q;
  assign bus.ppu_rdata_out    = src_q ? bus.oam_rdata_in : bus.vram_rdata_in;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    pass_d     = pass_q;
    pass_src_d = pass_src_q;
    ack_d      = 1'b0;
    blk_d      = blk_q;
    vram_vld_d = ppu_vram_gnt;
    oam_vld_d  = ppu_oam_gnt;
    src_d      = ppu_vram_gnt ? 1'b0 : ppu_oam_gnt ? 1'b1 : src_q;
    case (state_q)
      IDLE: if (bus.cpu_req_in) begin
        state_d = ISSUE;
        addr_d  = bus.cpu_addr_in;
        we_d    = bus.cpu_we_in;
        wdata_d = bus.cpu_wdata_in;
      end
      ISSUE: begin
        state_d    = RESP;
        ack_d      = 1'b1;
        pass_d     = (cpu_vram_go || cpu_oam_go) && !we_q;
        pass_src_d = !tgt_vram;
        rdata_d    = we_q ? 8'h00 : 8'hFF;
        blk_d      = (cpu_blocked && !(&blk_q)) ? blk_q + BLK_CNT_W'(1) : blk_q;
      end
      RESP: begin
        state_d = IDLE;
        pass_d  = 1'b0;
        rdata_d = pass_q ? bram_rdata : rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      pass_q     <= 1'b0;
      pass_src_q <= 1'b0;
      ack_q      <= 1'b0;
      blk_q      <= '0;
      vram_vld_q <= 1'b0;
      oam_vld_q  <= 1'b0;
      src_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      pass_q     <= pass_d;
      pass_src_q <= pass_src_d;
      ack_q      <= ack_d;
      blk_q      <= blk_d;
      vram_vld_q <= vram_vld_d;
      oam_vld_q  <= oam_vld_d;
      src_q      <= src_d;
    end
endmodule

// File: tb/tb_vram_oam_arbiter.sv
// tb_vram_oam_arbiter: directed vector table plus hand-written corner sequences with BRAM models.
module tb_vram_oam_arbiter;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  vram_oam_arbiter_if #(.BLK_CNT_W(W)) bus();
  vram_oam_arbiter #(.BLK_CNT_W(W)) dut (.clk_in(clk), .rst_in(rst), .bus(bus.slave));
  logic [7:0]  vmem [8192];
  logic [7:0]  omem [256];
  logic        pre_v = 1'b0, pre_o = 1'b0;
  logic [12:0] pre_a = '0;
  logic [7:0]  pre_d = '0;
  always @(posedge clk) begin
    if (pre_v) vmem[pre_a] <= pre_d;
    else if (bus.vram_we_out) vmem[bus.vram_addr_out] <= bus.vram_wdata_out;
    if (pre_o) omem[pre_a[7:0]] <= pre_d;
    else if (bus.oam_we_out) omem[bus.oam_addr_out] <= bus.oam_wdata_out;
    bus.vram_rdata_in <= vmem[bus.vram_addr_out];
    bus.oam_rdata_in  <= omem[bus.oam_addr_out];
  end
  int n_cmp = 0;
  int n_bad = 0;
  int exp_blk = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic poke(input logic is_oam, input logic [12:0] a, input logic [7:0] d);
    pre_v = !is_oam; pre_o = is_oam; pre_a = a; pre_d = d;
    step();
    pre_v = 1'b0; pre_o = 1'b0;
  endtask
  task automatic cpu_access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                            output int lat, output logic [7:0] rd, output logic wr_seen);
    bus.cpu_addr_in = a; bus.cpu_we_in = we; bus.cpu_wdata_in = wd; bus.cpu_req_in = 1'b1;
    lat = -1; rd = 8'h00; wr_seen = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (bus.vram_we_out || bus.oam_we_out) wr_seen = 1'b1;
      if (bus.cpu_ack_out) begin
        lat = n;
        rd = bus.cpu_rdata_out;
        break;
      end
    end
    bus.cpu_req_in = 1'b0;
  endtask
  typedef struct {
    logic        lcd;
    logic [1:0]  mode;
    logic        dma;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    int          exp_inc;
    logic        exp_wr;
  } vec_t;
  vec_t vt[11];
  initial begin
    int lat;
    logic [7:0] rd;
    logic wr_seen;
    int bad;
    int seen;
    bus.lcd_en_in = 1'b0; bus.ppu_mode_in = 2'd0; bus.cpu_req_in = 1'b0;
    bus.cpu_addr_in = '0; bus.cpu_we_in = 1'b0; bus.cpu_wdata_in = '0;
    bus.ppu_vram_rd_in = 1'b0; bus.ppu_vram_addr_in = '0;
    bus.ppu_oam_rd_in = 1'b0; bus.ppu_oam_addr_in = '0;
    bus.dma_active_in = 1'b0; bus.dma_we_in = 1'b0; bus.dma_addr_in = '0; bus.dma_wdata_in = '0;
    vt[0]  = '{1'b1, 2'd0, 1'b0, 16'h8010, 1'b0, 8'h00, 8'h5A, 0, 1'b0};
    vt[1]  = '{1'b1, 2'd3, 1'b0, 16'h8000, 1'b1, 8'h12, 8'h00, 1, 1'b0};
    vt[2]  = '{1'b0, 2'd3, 1'b0, 16'h8000, 1'b1, 8'h12, 8'h00, 0, 1'b1};
    vt[3]  = '{1'b1, 2'd2, 1'b0, 16'hFE00, 1'b0, 8'h00, 8'hFF, 1, 1'b0};
    vt[4]  = '{1'b1, 2'd3, 1'b0, 16'hFE20, 1'b0, 8'h00, 8'hFF, 1, 1'b0};
    vt[5]  = '{1'b1, 2'd1, 1'b0, 16'hFE20, 1'b0, 8'h00, 8'h77, 0, 1'b0};
    vt[6]  = '{1'b1, 2'd0, 1'b0, 16'hFEA5, 1'b0, 8'h00, 8'hFF, 0, 1'b0};
    vt[7]  = '{1'b1, 2'd2, 1'b0, 16'h9F00, 1'b0, 8'h00, 8'h3C, 0, 1'b0};
    vt[8]  = '{1'b1, 2'd3, 1'b0, 16'h9F00, 1'b0, 8'h00, 8'hFF, 1, 1'b0};
    vt[9]  = '{1'b0, 2'd3, 1'b1, 16'hFE20, 1'b0, 8'h00, 8'hFF, 1, 1'b0};
    vt[10] = '{1'b1, 2'd0, 1'b0, 16'hFE30, 1'b1, 8'hAB, 8'h00, 0, 1'b1};
    poke(1'b0, 13'h0010, 8'h5A);
    poke(1'b0, 13'h1F00, 8'h3C);
    poke(1'b1, 13'h0020, 8'h77);
    poke(1'b1, 13'h0004, 8'h44);
    chk("rst_ack", bus.cpu_ack_out, 0);
    chk("rst_rdata", bus.cpu_rdata_out, 0);
    chk("rst_blk", bus.cpu_blk_cnt_out, 0);
    chk("rst_vld", {bus.ppu_vram_vld_out, bus.ppu_oam_vld_out}, 0);
    rst = 1'b0;
    step();
    foreach (vt[i]) begin
      bus.lcd_en_in = vt[i].lcd; bus.ppu_mode_in = vt[i].mode; bus.dma_active_in = vt[i].dma;
      cpu_access(vt[i].addr, vt[i].we, vt[i].wdata, lat, rd, wr_seen);
      exp_blk += vt[i].exp_inc;
      chk($sformatf("v%0d_lat", i), lat, 2);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_blk", i), bus.cpu_blk_cnt_out, exp_blk);
      chk($sformatf("v%0d_bram_we", i), wr_seen, vt[i].exp_wr);
      if (vt[i].exp_wr)
        chk($sformatf("v%0d_landed", i),
            vt[i].addr[15:13] == 3'b100 ? vmem[vt[i].addr[12:0]] : omem[vt[i].addr[7:0]],
            vt[i].wdata);
      bus.dma_active_in = 1'b0;
      step();
    end
    // OAMScan: CPU OAM read blocked while the PPU reads OAM in the same cycle
    bus.lcd_en_in = 1'b1; bus.ppu_mode_in = 2'd2;
    bus.cpu_addr_in = 16'hFE00; bus.cpu_we_in = 1'b0; bus.cpu_req_in = 1'b1;
    step();
    bus.ppu_oam_rd_in = 1'b1; bus.ppu_oam_addr_in = 8'h04;
    #1;
    chk("scan_ppu_oam_gnt", bus.ppu_oam_gnt_out, 1);
    chk("scan_oam_addr", bus.oam_addr_out, 8'h04);
    step();
    bus.ppu_oam_rd_in = 1'b0;
    exp_blk++;
    chk("scan_oam_vld", bus.ppu_oam_vld_out, 1);
    chk("scan_ppu_rdata", bus.ppu_rdata_out, 8'h44);
    chk("scan_cpu_ack", bus.cpu_ack_out, 1);
    chk("scan_cpu_rdata", bus.cpu_rdata_out, 8'hFF);
    chk("scan_blk", bus.cpu_blk_cnt_out, exp_blk);
    bus.cpu_req_in = 1'b0;
    step();
    // VBlank: CPU VRAM issue holds off a PPU strobe for exactly one cycle
    bus.ppu_mode_in = 2'd1;
    bus.cpu_addr_in = 16'h8010; bus.cpu_req_in = 1'b1;
    step();
    bus.ppu_vram_rd_in = 1'b1; bus.ppu_vram_addr_in = 13'h1F00;
    #1;
    chk("vb_gnt_issue", bus.ppu_vram_gnt_out, 0);
    chk("vb_vram_addr_cpu", bus.vram_addr_out, 13'h0010);
    step();
    chk("vb_gnt_resp", bus.ppu_vram_gnt_out, 1);
    chk("vb_vld_resp", bus.ppu_vram_vld_out, 0);
    chk("vb_cpu_ack", bus.cpu_ack_out, 1);
    chk("vb_cpu_rdata", bus.cpu_rdata_out, 8'h5A);
    bus.cpu_req_in = 1'b0;
    step();
    bus.ppu_vram_rd_in = 1'b0;
    chk("vb_vld", bus.ppu_vram_vld_out, 1);
    chk("vb_ppu_rdata", bus.ppu_rdata_out, 8'h3C);
    step();
    // OAM DMA during OAMScan with PPU strobes
    bus.dma_active_in = 1'b1; bus.dma_we_in = 1'b0;
    bus.ppu_oam_rd_in = 1'b1; bus.ppu_oam_addr_in = 8'h04;
    #1;
    chk("dma_idle_we", bus.oam_we_out, 0);
    chk("dma_idle_gnt", bus.ppu_oam_gnt_out, 0);
    step();
    for (int i = 0; i < 160; i++) begin
      bus.dma_we_in = 1'b1; bus.dma_addr_in = 8'(i); bus.dma_wdata_in = 8'(i) ^ 8'h5A;
      bus.ppu_oam_addr_in = 8'(i);
      #1;
      chk($sformatf("dma_ppu_gnt%0d", i), bus.ppu_oam_gnt_out, 0);
      chk($sformatf("dma_we%0d", i), bus.oam_we_out, 1);
      step();
    end
    bus.dma_we_in = 1'b0; bus.dma_active_in = 1'b0; bus.ppu_oam_rd_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 160; i++) if (omem[i] !== (8'(i) ^ 8'h5A)) bad++;
    chk("dma_landed_bad", bad, 0);
    // Async reset while an access is in ISSUE
    bus.ppu_mode_in = 2'd3;
    bus.cpu_addr_in = 16'h8000; bus.cpu_we_in = 1'b1; bus.cpu_req_in = 1'b1;
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", bus.cpu_ack_out, 0);
    chk("rst_mid_blk", bus.cpu_blk_cnt_out, 0);
    #2;
    rst = 1'b0; bus.cpu_req_in = 1'b0;
    exp_blk = 0;
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      step();
      if (bus.cpu_ack_out) seen++;
    end
    chk("rst_mid_no_ack", seen, 0);
    chk("rst_mid_blk_after", bus.cpu_blk_cnt_out, 0);
    bus.ppu_mode_in = 2'd0;
    cpu_access(16'h8010, 1'b0, 8'h00, lat, rd, wr_seen);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_rdata", rd, 8'h5A);
    step();
    // Saturation of the blocked-access counter
    bus.ppu_mode_in = 2'd3;
    for (int n = 0; n < (1 << W) + 1; n++) begin
      cpu_access(16'h8000, 1'b1, 8'h99, lat, rd, wr_seen);
      exp_blk = (exp_blk == (1 << W) - 1) ? exp_blk : exp_blk + 1;
      chk($sformatf("sat%0d", n), bus.cpu_blk_cnt_out, exp_blk);
      step();
    end
    chk("sat_final", bus.cpu_blk_cnt_out, (1 << W) - 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
